// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: data width, RV32I
// load/store funct3 encodings and the controller state encoding.
package dmem_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Data-bus valid/ready interface between the controller (master) and memory.
interface dmem_ctrl_if;
  import dmem_ctrl_pkg::*;

  logic            valid;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      wstrb;
  logic [XLEN-1:0] wdata;
  logic            ready;
  logic [XLEN-1:0] rdata;

  modport master (output valid, we, addr, wstrb, wdata, input ready, rdata);
  modport slave  (input valid, we, addr, wstrb, wdata, output ready, rdata);

endinterface

// File: rtl/dmem_ctrl_lane_align.sv
// Combinational byte-lane logic: access legality, store strobes and lane
// replication, and load extraction with sign/zero extension.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic            i_we,
  input  logic [1:0]      i_off,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_bus_rdata,
  output logic            o_illegal,
  output logic [3:0]      o_wstrb,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_rdata
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = i_bus_rdata >> {i_off, 3'b000};

  // Legality: halfwords need even addresses, words need word alignment,
  // unsigned variants exist only for loads, everything else is reserved.
  always_comb begin
    o_illegal = 1'b1;
    case (i_funct3)
      F3_B:    o_illegal = 1'b0;
      F3_H:    o_illegal = i_off[0];
      F3_W:    o_illegal = |i_off;
      F3_BU:   o_illegal = i_we;
      F3_HU:   o_illegal = i_we | i_off[0];
      default: o_illegal = 1'b1;
    endcase
  end

  // Store side: strobe the addressed lanes and replicate data across the word.
  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = i_wdata;
    case (i_funct3)
      F3_B: begin
        o_wstrb = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        o_wstrb = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      F3_W:    o_wstrb = 4'b1111;
      default: o_wstrb = 4'b0000;
    endcase
    if (!i_we) o_wstrb = 4'b0000;
  end

  // Load side: right-justify the addressed lanes, then extend.
  always_comb begin
    o_rdata = w_shifted;
    case (i_funct3)
      F3_B:    o_rdata = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_BU:   o_rdata = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      F3_H:    o_rdata = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_HU:   o_rdata = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      default: o_rdata = w_shifted;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: latches the memory stage's level request, runs one
// valid/ready bus transfer (or none for illegal accesses), returns a one-cycle
// ack with extended load data, then waits for the request to drop.
// Optional macro DMEM_TIMEOUT_EN adds a bus wait limit of TIMEOUT_CYCLES.
module dmem_ctrl #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req,
  input  logic            i_we,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [2:0]      i_funct3,
  output logic            o_ack,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_err,
  output logic            o_bus_valid,
  output logic            o_bus_we,
  output logic [XLEN-1:0] o_bus_addr,
  output logic [3:0]      o_bus_wstrb,
  output logic [XLEN-1:0] o_bus_wdata,
  input  logic            i_bus_ready,
  input  logic [XLEN-1:0] i_bus_rdata
);

  typedef dmem_ctrl_pkg::state_t state_t;

  state_t          r_state, w_state_nxt;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [2:0]      r_funct3;
  logic            r_err;
  logic [XLEN-1:0] r_rdata;

  logic            w_illegal;
  logic            w_timeout;
  logic            w_to_resp;
  logic            w_err_nxt;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_rdata;

  dmem_lane_align u_align (
    .i_we        (r_we),
    .i_off       (r_addr[1:0]),
    .i_funct3    (r_funct3),
    .i_wdata     (r_wdata),
    .i_bus_rdata (i_bus_rdata),
    .o_illegal   (w_illegal),
    .o_wstrb     (w_wstrb),
    .o_wdata     (w_wdata),
    .o_rdata     (w_rdata)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_wait_cnt;

  // Count unanswered BUS cycles; held at zero outside BUS so each entry starts clean.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                            r_wait_cnt <= '0;
    else if (r_state == dmem_ctrl_pkg::S_BUS && !i_bus_ready) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    else                                                     r_wait_cnt <= '0;
  end

  assign w_timeout = (r_state == dmem_ctrl_pkg::S_BUS) && !w_illegal && !i_bus_ready &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Illegal accesses spend their BUS cycle with valid suppressed, keeping
  // the same two-cycle ack latency as a zero-wait legal access.
  assign w_err_nxt = w_illegal | w_timeout;

  // Next-state and output decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_to_resp    = 1'b0;
    o_ack        = 1'b0;
    o_bus_valid  = 1'b0;
    o_bus_we     = r_we;
    o_bus_addr   = {r_addr[XLEN-1:2], 2'b00};
    o_bus_wstrb  = w_wstrb;
    o_bus_wdata  = w_wdata;
    case (r_state)
      dmem_ctrl_pkg::S_IDLE: if (i_req) w_state_nxt = dmem_ctrl_pkg::S_BUS;
      dmem_ctrl_pkg::S_BUS: begin
        o_bus_valid = !w_illegal;
        if (w_illegal || i_bus_ready || w_timeout) begin
          w_state_nxt = dmem_ctrl_pkg::S_RESP;
          w_to_resp   = 1'b1;
        end
      end
      dmem_ctrl_pkg::S_RESP: begin
        o_ack       = 1'b1;
        w_state_nxt = dmem_ctrl_pkg::S_HOLD;
      end
      dmem_ctrl_pkg::S_HOLD: if (!i_req) w_state_nxt = dmem_ctrl_pkg::S_IDLE;
      default: w_state_nxt = dmem_ctrl_pkg::S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= dmem_ctrl_pkg::S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Latch the request once in IDLE; later input changes are ignored.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
    end else if (r_state == dmem_ctrl_pkg::S_IDLE && i_req) begin
      r_we     <= i_we;
      r_addr   <= i_addr;
      r_wdata  <= i_wdata;
      r_funct3 <= i_funct3;
    end
  end

  // Response capture: errors zero the load data, stores leave it untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (w_to_resp) begin
      r_err <= w_err_nxt;
      if (w_err_nxt)  r_rdata <= '0;
      else if (!r_we) r_rdata <= w_rdata;
    end
  end

  assign o_err   = r_err;
  assign o_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a table of single transactions plus
// hand-written sequences for request drop, reset mid-transfer and timeout.
module tb_dmem_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [2:0]  i_funct3;
  logic        o_ack;
  logic [31:0] o_rdata;
  logic        o_err;
  logic        o_bus_valid;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_wstrb;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;

  dmem_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(4)) u_dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_funct3    (i_funct3),
    .o_ack       (o_ack),
    .o_rdata     (o_rdata),
    .o_err       (o_err),
    .o_bus_valid (o_bus_valid),
    .o_bus_we    (o_bus_we),
    .o_bus_addr  (o_bus_addr),
    .o_bus_wstrb (o_bus_wstrb),
    .o_bus_wdata (o_bus_wdata),
    .i_bus_ready (i_bus_ready),
    .i_bus_rdata (i_bus_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          waits;
    logic [31:0] brdata;
    logic        legal;
    logic [3:0]  wstrb;
    logic [31:0] bwdata;
    logic        err;
    logic [31:0] rdata;
    int          hold;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int  cyc;
    bit  got;
    int  lat;
    i_req = 1'b1; i_we = v.we; i_addr = v.addr; i_wdata = v.wdata; i_funct3 = v.f3;
    i_bus_ready = 1'b0; i_bus_rdata = 32'h0;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge i_clk);
      cyc++;
      if (o_ack === 1'b1) begin
        got = 1'b1;
      end else begin
        chk({nm, "_valid"}, {31'b0, o_bus_valid}, {31'b0, v.legal});
        if (v.legal) begin
          chk({nm, "_we"},    {31'b0, o_bus_we}, {31'b0, v.we});
          chk({nm, "_addr"},  o_bus_addr, {v.addr[31:2], 2'b00});
          chk({nm, "_wstrb"}, {28'b0, o_bus_wstrb}, {28'b0, v.wstrb});
          chk({nm, "_wdata"}, o_bus_wdata, v.bwdata);
        end
        if (v.legal && cyc == v.waits + 1) begin
          i_bus_ready = 1'b1; i_bus_rdata = v.brdata;
        end else begin
          i_bus_ready = 1'b0; i_bus_rdata = 32'h0;
        end
      end
    end
    i_bus_ready = 1'b0;
    lat = v.legal ? v.waits + 2 : 2;
    chk({nm, "_ack"}, {31'b0, got}, 32'd1);
    chk({nm, "_latency"}, cyc, lat);
    chk({nm, "_err"}, {31'b0, o_err}, {31'b0, v.err});
    chk({nm, "_rdata"}, o_rdata, v.rdata);
    chk({nm, "_valid_at_ack"}, {31'b0, o_bus_valid}, 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge i_clk);
      chk({nm, "_no_reack"}, {31'b0, o_ack}, 32'd0);
    end
    i_req = 1'b0;
    for (int h = 0; h < 2; h++) begin
      @(negedge i_clk);
      chk({nm, "_idle_ack"}, {31'b0, o_ack}, 32'd0);
    end
  endtask

  initial begin
    int cyc;
    bit got;
    //          we    addr          wdata         f3      wt brdata        lg    wstrb    bwdata        err   rdata         hold
    vecs[0]  = '{1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 3'b010, 0, 32'h0,         1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 0};
    vecs[1]  = '{1'b1, 32'h0000_0203, 32'h0000_00A5, 3'b000, 0, 32'h0,         1'b1, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0000_0000, 0};
    vecs[2]  = '{1'b0, 32'h0000_0203, 32'h0,         3'b000, 0, 32'hA500_0000, 1'b1, 4'b0000, 32'h0,         1'b0, 32'hFFFF_FFA5, 0};
    vecs[3]  = '{1'b0, 32'h0000_0203, 32'h0,         3'b100, 0, 32'hA500_0000, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_00A5, 0};
    vecs[4]  = '{1'b0, 32'h0000_0302, 32'h0,         3'b001, 3, 32'h8001_1234, 1'b1, 4'b0000, 32'h0,         1'b0, 32'hFFFF_8001, 0};
    vecs[5]  = '{1'b0, 32'h0000_0101, 32'h0,         3'b010, 0, 32'h0,         1'b0, 4'b0000, 32'h0,         1'b1, 32'h0000_0000, 3};
    vecs[6]  = '{1'b1, 32'h0000_0102, 32'h0000_BEEF, 3'b001, 1, 32'h0,         1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0000_0000, 0};
    vecs[7]  = '{1'b0, 32'h0000_0100, 32'h0,         3'b101, 0, 32'h1234_8765, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_8765, 0};
    vecs[8]  = '{1'b0, 32'h0000_0100, 32'h0,         3'b010, 1, 32'hCAFE_F00D, 1'b1, 4'b0000, 32'h0,         1'b0, 32'hCAFE_F00D, 0};
    vecs[9]  = '{1'b0, 32'h0000_0100, 32'h0,         3'b011, 0, 32'h0,         1'b0, 4'b0000, 32'h0,         1'b1, 32'h0000_0000, 0};
    vecs[10] = '{1'b1, 32'h0000_0100, 32'h1111_1111, 3'b011, 0, 32'h0,         1'b0, 4'b0000, 32'h0,         1'b1, 32'h0000_0000, 0};
    vecs[11] = '{1'b0, 32'h0000_0101, 32'h0,         3'b000, 0, 32'h0000_7F00, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_007F, 0};
    vecs[12] = '{1'b1, 32'h0000_0001, 32'h0000_1234, 3'b000, 2, 32'h0,         1'b1, 4'b0010, 32'h3434_3434, 1'b0, 32'h0000_007F, 0};
    vecs[13] = '{1'b0, 32'h0000_0103, 32'h0,         3'b001, 0, 32'h0,         1'b0, 4'b0000, 32'h0,         1'b1, 32'h0000_0000, 1};
    vecs[14] = '{1'b1, 32'h0000_0101, 32'h0000_5555, 3'b001, 0, 32'h0,         1'b0, 4'b0000, 32'h0,         1'b1, 32'h0000_0000, 0};
    vecs[15] = '{1'b0, 32'h0000_0302, 32'h0,         3'b000, 0, 32'h0080_0000, 1'b1, 4'b0000, 32'h0,         1'b0, 32'hFFFF_FF80, 0};

    i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0; i_funct3 = '0;
    i_bus_ready = 1'b0; i_bus_rdata = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_ack",   {31'b0, o_ack}, 32'd0);
    chk("rst_err",   {31'b0, o_err}, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_valid", {31'b0, o_bus_valid}, 32'd0);
    chk("rst_wstrb", {28'b0, o_bus_wstrb}, 32'd0);
    chk("rst_addr",  o_bus_addr, 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Request withdrawn right after capture: transfer completes, HOLD exits at once.
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0200; i_funct3 = 3'b010;
    @(negedge i_clk);
    chk("drop_valid", {31'b0, o_bus_valid}, 32'd1);
    i_req = 1'b0; i_addr = 32'h0000_0FFF;
    i_bus_ready = 1'b1; i_bus_rdata = 32'h1122_3344;
    @(negedge i_clk);
    i_bus_ready = 1'b0;
    chk("drop_ack",   {31'b0, o_ack}, 32'd1);
    chk("drop_rdata", o_rdata, 32'h1122_3344);
    chk("drop_err",   {31'b0, o_err}, 32'd0);
    @(negedge i_clk);
    chk("drop_single_ack", {31'b0, o_ack}, 32'd0);
    @(negedge i_clk);

`ifdef DMEM_TIMEOUT_EN
    // Bus never answers: four BUS cycles, then error response.
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0040; i_funct3 = 3'b010;
    i_bus_ready = 1'b0;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge i_clk);
      cyc++;
      if (o_ack === 1'b1) got = 1'b1;
      else chk("tmo_valid", {31'b0, o_bus_valid}, 32'd1);
    end
    chk("tmo_ack",      {31'b0, got}, 32'd1);
    chk("tmo_latency",  cyc, 32'd5);
    chk("tmo_err",      {31'b0, o_err}, 32'd1);
    chk("tmo_rdata",    o_rdata, 32'd0);
    chk("tmo_valid_lo", {31'b0, o_bus_valid}, 32'd0);
    i_req = 1'b0;
    repeat (2) @(negedge i_clk);
`endif

    // Reset in the middle of a waiting bus cycle.
    i_req = 1'b1; i_we = 1'b1; i_addr = 32'h0000_0104; i_wdata = 32'h0BAD_F00D; i_funct3 = 3'b010;
    @(negedge i_clk);
    chk("rstmid_valid_before", {31'b0, o_bus_valid}, 32'd1);
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rstmid_valid", {31'b0, o_bus_valid}, 32'd0);
    chk("rstmid_ack",   {31'b0, o_ack}, 32'd0);
    i_req = 1'b0;
    @(negedge i_clk);
    chk("rstmid_no_ack", {31'b0, o_ack}, 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    run_vec('{1'b0, 32'h0000_0108, 32'h0, 3'b010, 0, 32'h5A5A_0F0F, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h5A5A_0F0F, 0},
            "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the memory stage.
- Accepts the memory stage's level-held request (addr, right-justified write data, funct3, read/write) and runs a valid/ready transaction on the data bus.
- Handles byte-lane strobes and write-data replication, load extraction and sign/zero extension, and misaligned or illegal access detection.
- Returns a one-cycle ack pulse with load data.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT_CYCLES, 255, bus wait limit; used only with DMEM_TIMEOUT_EN.

Ports:
- i_clk  in  1  CPU clock.
- i_rst_n  in  1  reset.
- i_req  in  1  request from memory stage; level, held until o_ack.
- i_we  in  1  0=load, 1=store.
- i_addr  in  XLEN  byte address.
- i_wdata  in  XLEN  store data, right-justified.
- i_funct3  in  3  access size/signedness (RV32I load/store encoding).
- o_ack  out  1  one-cycle completion pulse.
- o_rdata  out  XLEN  extended load data; valid with o_ack, held until next ack.
- o_err  out  1  misaligned/illegal/timeout flag; valid with o_ack.
- o_bus_valid  out  1  bus request.
- o_bus_we  out  1  bus write.
- o_bus_addr  out  XLEN  word-aligned address ({i_addr[XLEN-1:2],2'b00}).
- o_bus_wstrb  out  4  byte write strobes; 0 on reads.
- o_bus_wdata  out  XLEN  lane-replicated write data.
- i_bus_ready  in  1  bus accepts/completes the transfer this cycle.
- i_bus_rdata  in  XLEN  read word; valid when i_bus_ready is high on a read.

Behaviour:
- Reset: i_rst_n is asynchronous and active-low; the clock is i_clk. All outputs and the state register clear to 0 (IDLE) immediately. Reset mid-transaction drops o_bus_valid at once; no ack is produced.
- Request capture, IDLE: when i_req=1, latch i_we, i_addr, i_wdata and i_funct3. After capture, input changes are ignored until the next IDLE.
- Legality check on the latched request:
  - LH, LHU or SH with addr[0]=1 is illegal.
  - LW or SW with addr[1:0]≠0 is illegal.
  - Loads with funct3 011/110/111 are illegal.
  - Stores with funct3 ≥011 are illegal.
  - Illegal: go to RESP with err=1 and rdata=0. No bus cycle occurs.
  - Legal: go to BUS.
- BUS:
  - o_bus_valid=1; addr, we, wstrb and wdata stay stable until i_bus_ready.
  - On i_bus_ready=1 (may be the first BUS cycle), capture the extracted read data and go to RESP.
  - o_bus_valid is deasserted in the cycle after ready.
- RESP: o_ack=1 for exactly one cycle, o_err set as determined above, o_rdata updated (loads only). Then go to HOLD.
- HOLD: wait for i_req=0, then go to IDLE. This prevents re-issue while the memory stage is still deasserting its request.
- Latency: i_req sampled at edge N; o_bus_valid from N+1; with ready at N+1, o_ack at N+2. Each wait-state cycle adds 1.
- Store lanes:
  - SB: wstrb=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: wstrb=0011<<(2*addr[1]), wdata={2{wdata[15:0]}}.
  - SW: wstrb=1111, wdata as-is.
- Load extract: shifted = i_bus_rdata >> (8*addr[1:0]).
  - LB sign-extends shifted[7:0]; LBU zero-extends it.
  - LH sign-extends shifted[15:0]; LHU zero-extends it.
  - LW passes the full word.
- Stores do not modify o_rdata.
- i_req falling before ack (protocol violation): the transaction still completes; HOLD exits immediately.

Optional Feature:
- DMEM_TIMEOUT_EN defined:
  - An 8+-bit wait counter clears on entering BUS and increments each BUS cycle without ready.
  - When it reaches TIMEOUT_CYCLES, drop o_bus_valid and go to RESP with o_err=1 and o_rdata=0.
- Undefined: BUS waits indefinitely and no counter is instantiated.

Decomposition:
- Shared package/header:
  - XLEN.
  - funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101).
  - State encoding (IDLE, BUS, RESP, HOLD; 2 bits).
- Sub-module dmem_lane_align, purely combinational, containing:
  - the legality check;
  - strobe/wdata generation;
  - load extraction and extension.
- The FSM stays in dmem_ctrl.

Test Plan:
- SW addr 0x104, data 0xDEADBEEF, ready on first BUS cycle -> bus addr 0x104, wstrb 1111, wdata 0xDEADBEEF; o_ack 2 cycles after req, err=0.
- SB addr 0x203, data 0x000000A5 -> wstrb 1000, wdata 0xA5A5A5A5; then LB at the same address with bus rdata 0xA5000000 -> o_rdata 0xFFFFFFA5; LBU -> 0x000000A5.
- LH addr 0x302, bus rdata 0x8001xxxx with 3 wait states -> ack 5 cycles after req, o_rdata 0xFFFF8001.
- LW addr 0x101 -> no o_bus_valid, ack 2 cycles after req, err=1, rdata 0; req held high after ack -> no second ack until req drops.
- Reset asserted during BUS wait -> o_bus_valid and o_ack are 0 immediately; next request after reset completes normally.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, ready never asserted -> valid drops, ack with err=1 after 4 BUS cycles.
